computer: RTL and testbench

COMPUTER -- requirements
Module: computer

---
 rtl/computer_pkg.sv | 36 +++
 rtl/computer_alu.sv | 27 ++
 rtl/computer.sv | 106 ++++++++++
 tb/tb_computer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared types and constants for the 8-bit accumulator-style computer.
package computer_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_COPY = 2'b01,
    OP_CALC = 2'b10,
    OP_COND = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_INV  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    C_NEVER  = 3'b000,
    C_EQZ    = 3'b001,
    C_LTZ    = 3'b010,
    C_LEZ    = 3'b011,
    C_ALWAYS = 3'b100,
    C_NEZ    = 3'b101,
    C_GEZ    = 3'b110,
    C_GTZ    = 3'b111
  } cond_e;

  localparam logic [2:0] IDX_NULL = 3'd6;
  localparam logic [2:0] IDX_IO   = 3'd7;

endpackage

// File: rtl/computer_alu.sv
// Combinational ALU for CALC; op 111 flags invalid and yields zero.
module computer_alu
  import computer_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  alu_op_e    i_op,
  output logic [7:0] o_result,
  output logic       o_invalid
);

  always_comb begin
    o_result  = '0;
    o_invalid = 1'b0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NAND: o_result = ~(i_a & i_b);
      ALU_NOR:  o_result = ~(i_a | i_b);
      default:  o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/computer.sv
// Single-cycle 8-bit CPU: 256x8 program memory, r0..r5, I/O via index 7.
module computer
  import computer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] in_data,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] out_data,
  output logic [7:0] pc,
  output logic       panic
);

  logic [7:0] r_mem  [0:255];
  logic [7:0] r_regs [0:5];
  logic [7:0] r_pc;
  logic [7:0] r_out;
  logic       r_panic;

  logic [7:0] w_instr;
  opcode_e    w_opcode;
  logic [2:0] w_src;
  logic [2:0] w_dst;
  logic [7:0] w_src_val;
  logic [7:0] w_alu_result;
  logic       w_alu_invalid;
  logic       w_taken;
  logic [7:0] w_pc_next;
  logic       w_zero;
  logic       w_neg;

  // Program memory is not touched by rst so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  assign w_instr  = r_mem[r_pc];
  assign w_opcode = opcode_e'(w_instr[7:6]);
  assign w_src    = w_instr[5:3];
  assign w_dst    = w_instr[2:0];

  always_comb begin
    w_src_val = '0;
    if (w_src < IDX_NULL) w_src_val = r_regs[w_src];
    else if (w_src == IDX_IO) w_src_val = in_data;
  end

  computer_alu u_alu (
    .i_a      (r_regs[1]),
    .i_b      (r_regs[2]),
    .i_op     (alu_op_e'(w_instr[2:0])),
    .o_result (w_alu_result),
    .o_invalid(w_alu_invalid)
  );

  assign w_zero = (r_regs[3] == 8'd0);
  assign w_neg  = r_regs[3][7];

  always_comb begin
    w_taken = 1'b0;
    case (cond_e'(w_instr[2:0]))
      C_NEVER:  w_taken = 1'b0;
      C_EQZ:    w_taken = w_zero;
      C_LTZ:    w_taken = w_neg;
      C_LEZ:    w_taken = w_neg | w_zero;
      C_ALWAYS: w_taken = 1'b1;
      C_NEZ:    w_taken = ~w_zero;
      C_GEZ:    w_taken = ~w_neg;
      C_GTZ:    w_taken = ~w_neg & ~w_zero;
      default:  w_taken = 1'b0;
    endcase
  end

  assign w_pc_next = (w_opcode == OP_COND && w_taken) ? r_regs[0] : r_pc + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_regs  <= '{default: '0};
      r_out   <= '0;
      r_panic <= 1'b0;
    end else if (run) begin
      r_pc <= w_pc_next;
      case (w_opcode)
        OP_IMM:  r_regs[0] <= {2'b00, w_instr[5:0]};
        OP_COPY: begin
          if (w_dst == IDX_IO) r_out <= w_src_val;
          else if (w_dst != IDX_NULL) r_regs[w_dst] <= w_src_val;
        end
        OP_CALC: begin
          r_regs[3] <= w_alu_result;
          if (w_alu_invalid) r_panic <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;
  assign pc       = r_pc;
  assign panic    = r_panic;

endmodule

// File: tb/tb_computer.sv
// Directed programs with a scoreboard queue checked by a negedge monitor.
module tb_computer;

  logic       clk = 1'b0;
  logic       rst, run, prog_we;
  logic [7:0] in_data, prog_addr, prog_data;
  logic [7:0] out_data, pc;
  logic       panic;

  computer dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .in_data  (in_data),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .out_data (out_data),
    .pc       (pc),
    .panic    (panic)
  );

  always #5 clk = ~clk;

  localparam int SEL_PC = 8, SEL_OUT = 9, SEL_PANIC = 10, SEL_MEM = 11;

  typedef struct {
    int unsigned when;
    int          sel;
    logic [7:0]  addr;
    logic [7:0]  exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned edges = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [7:0] probe(input int sel, input logic [7:0] addr);
    case (sel)
      0:         return dut.r_regs[0];
      1:         return dut.r_regs[1];
      2:         return dut.r_regs[2];
      3:         return dut.r_regs[3];
      4:         return dut.r_regs[4];
      5:         return dut.r_regs[5];
      SEL_PC:    return pc;
      SEL_OUT:   return out_data;
      SEL_PANIC: return {7'd0, panic};
      SEL_MEM:   return dut.r_mem[addr];
      default:   return 8'hxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].when <= edges) begin
      exp_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = probe(e.sel, e.addr);
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s @edge %0d: got %02h expected %02h", e.name, edges, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic exp_at(input int unsigned when, input int sel, input logic [7:0] addr,
                        input logic [7:0] v, input string name);
    exp_t e;
    e.when = when; e.sel = sel; e.addr = addr; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base;
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; in_data = '0;
    tick(1);

    // Program 1: in -> r1, r1 -> r2, in -> r1, r3 = r1 + r2, r3 -> out
    wr(8'd0, 8'b01_111_001);
    wr(8'd1, 8'b01_001_010);
    wr(8'd2, 8'b01_111_001);
    wr(8'd3, 8'b10_000_000);
    wr(8'd4, 8'b01_011_111);
    exp_at(edges, SEL_PC, 0, 8'h00, "reset_pc");
    exp_at(edges, SEL_OUT, 0, 8'h00, "reset_out");
    exp_at(edges, SEL_PANIC, 0, 8'h00, "reset_panic");
    for (int i = 0; i < 6; i++) exp_at(edges, i, 0, 8'h00, "reset_reg");

    rst = 1'b0; run = 1'b1; in_data = 8'd4;
    base = edges;
    exp_at(base + 2, SEL_PC, 0, 8'h02, "p1_pc_pre_hold");
    exp_at(base + 2, 1, 0, 8'h04, "p1_r1_pre_hold");
    exp_at(base + 2, 2, 0, 8'h04, "p1_r2_pre_hold");
    exp_at(base + 5, SEL_PC, 0, 8'h02, "hold_pc");
    exp_at(base + 5, 1, 0, 8'h04, "hold_r1");
    exp_at(base + 5, 2, 0, 8'h04, "hold_r2");
    exp_at(base + 5, 3, 0, 8'h00, "hold_r3");
    exp_at(base + 8, 1, 0, 8'h05, "p1_r1");
    exp_at(base + 8, 2, 0, 8'h04, "p1_r2");
    exp_at(base + 8, 3, 0, 8'h09, "p1_r3");
    exp_at(base + 8, SEL_OUT, 0, 8'h09, "p1_out");
    exp_at(base + 8, SEL_PC, 0, 8'h05, "p1_pc");
    tick(2);
    run = 1'b0; in_data = 8'd5;
    tick(3);
    run = 1'b1;
    tick(3);
    run = 1'b0;

    // Program 2: IMM/copy out, SUB wrap, branches, invalid op
    rst = 1'b1;
    tick(1);
    wr(8'd0, 8'h3F); wr(8'd1, 8'h47); wr(8'd2, 8'h03); wr(8'd3, 8'h41);
    wr(8'd4, 8'h05); wr(8'd5, 8'h42); wr(8'd6, 8'h81); wr(8'd7, 8'h04);
    wr(8'd8, 8'h42); wr(8'd9, 8'h71); wr(8'd10, 8'h81); wr(8'd11, 8'h10);
    wr(8'd12, 8'hC7); wr(8'd13, 8'hC2); wr(8'd16, 8'h87); wr(8'd17, 8'h77);
    rst = 1'b0; run = 1'b1;
    base = edges;
    exp_at(base + 2, SEL_OUT, 0, 8'h3F, "imm_copy_out");
    exp_at(base + 2, SEL_PC, 0, 8'h02, "imm_copy_pc");
    exp_at(base + 7, 3, 0, 8'hFE, "sub_wrap_r3");
    exp_at(base + 7, SEL_PANIC, 0, 8'h00, "sub_no_panic");
    exp_at(base + 11, 3, 0, 8'hFC, "sub_fc_r3");
    exp_at(base + 12, 0, 0, 8'h10, "branch_target_r0");
    exp_at(base + 13, SEL_PC, 0, 8'h0D, "cond_gt_not_taken");
    exp_at(base + 14, SEL_PC, 0, 8'h10, "cond_lt_taken");
    exp_at(base + 15, 3, 0, 8'h00, "invalid_r3");
    exp_at(base + 15, SEL_PANIC, 0, 8'h01, "invalid_panic");
    exp_at(base + 15, SEL_PC, 0, 8'h11, "invalid_pc");
    exp_at(base + 16, SEL_OUT, 0, 8'h00, "null_to_out");
    exp_at(base + 16, SEL_PANIC, 0, 8'h01, "panic_sticky");
    tick(16);
    run = 1'b0;

    // Mid-program reset with run high
    run = 1'b1; rst = 1'b1;
    base = edges;
    exp_at(base + 1, SEL_PC, 0, 8'h00, "rst_pc");
    exp_at(base + 1, SEL_OUT, 0, 8'h00, "rst_out");
    exp_at(base + 1, SEL_PANIC, 0, 8'h00, "rst_panic");
    exp_at(base + 1, 0, 0, 8'h00, "rst_r0");
    exp_at(base + 1, 3, 0, 8'h00, "rst_r3");
    exp_at(base + 1, SEL_MEM, 8'd0, 8'h3F, "rst_mem0");
    exp_at(base + 1, SEL_MEM, 8'd13, 8'hC2, "rst_mem13");
    exp_at(base + 1, SEL_MEM, 8'd17, 8'h77, "rst_mem17");
    tick(1);
    run = 1'b0;

    // Program 3: jump to 0xFF, non-branch there wraps pc to 0
    wr(8'd0, 8'b01_111_000);
    wr(8'd1, 8'hC4);
    wr(8'd255, 8'h2A);
    rst = 1'b0; run = 1'b1; in_data = 8'hFF;
    base = edges;
    exp_at(base + 1, 0, 0, 8'hFF, "in_to_r0");
    exp_at(base + 2, SEL_PC, 0, 8'hFF, "jump_ff");
    exp_at(base + 3, SEL_PC, 0, 8'h00, "pc_wrap");
    exp_at(base + 3, 0, 0, 8'h2A, "wrap_imm_r0");
    tick(3);
    run = 1'b0;

    tick(3);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
